// File: rtl/alu_pkg.sv
// Shared definitions for the iterative ALU.
// Op codes, FSM state encoding and default width.
package alu_pkg;
  localparam int XLEN_DEFAULT = 32;

  localparam logic [4:0] OP_ADD    = 5'h00;
  localparam logic [4:0] OP_SUB    = 5'h01;
  localparam logic [4:0] OP_NOT    = 5'h02;
  localparam logic [4:0] OP_AND    = 5'h03;
  localparam logic [4:0] OP_OR     = 5'h04;
  localparam logic [4:0] OP_XOR    = 5'h05;
  localparam logic [4:0] OP_SLT    = 5'h06;
  localparam logic [4:0] OP_SLTU   = 5'h07;
  localparam logic [4:0] OP_SLL    = 5'h08;
  localparam logic [4:0] OP_SRL    = 5'h09;
  localparam logic [4:0] OP_SRA    = 5'h0A;
  localparam logic [4:0] OP_EQ     = 5'h0B;
  localparam logic [4:0] OP_MUL    = 5'h0C;
  localparam logic [4:0] OP_MULH   = 5'h0D;
  localparam logic [4:0] OP_MULHSU = 5'h0E;
  localparam logic [4:0] OP_MULHU  = 5'h0F;
  localparam logic [4:0] OP_DIV    = 5'h10;
  localparam logic [4:0] OP_DIVU   = 5'h11;
  localparam logic [4:0] OP_REM    = 5'h12;
  localparam logic [4:0] OP_REMU   = 5'h13;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

  function automatic logic is_mul(input logic [4:0] op);
    return (op >= OP_MUL) && (op <= OP_MULHU);
  endfunction

  function automatic logic is_div(input logic [4:0] op);
    return (op >= OP_DIV) && (op <= OP_REMU);
  endfunction
endpackage

// File: rtl/alu_muldiv_iter.sv
// Shift-add multiplier / restoring divider on operand magnitudes.
// start/op/a/b load; state steps MUL/DIV; last ends iterations; res valid in FIX.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  state_t          state,
  output logic            last,
  output logic [XLEN-1:0] res
);
  localparam int CW = $clog2(XLEN) + 1;

  logic [4:0]      op_q;
  logic            neg;
  logic            neg_r;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [XLEN-1:0] mc;
  logic [CW-1:0]   cnt;

  logic            sa;
  logic            sb;
  logic [XLEN-1:0] ma;
  logic [XLEN-1:0] mb;
  logic [XLEN:0]   sum;
  logic [XLEN:0]   t;
  logic            ge;
  logic [XLEN-1:0] d;
  logic [2*XLEN-1:0] pf;
  logic [XLEN-1:0] qf;
  logic [XLEN-1:0] rf;

  assign sa = a[XLEN-1] & ((op == OP_MUL) | (op == OP_MULH) |
              (op == OP_MULHSU) | (op == OP_DIV) | (op == OP_REM));
  assign sb = b[XLEN-1] & ((op == OP_MUL) | (op == OP_MULH) |
              (op == OP_DIV) | (op == OP_REM));
  assign ma = sa ? -a : a;
  assign mb = sb ? -b : b;

  // hi:lo is the product accumulator, or remainder:quotient when dividing
  assign sum = {1'b0, hi} + (lo[0] ? {1'b0, mc} : '0);
  assign t   = {hi, lo[XLEN-1]};
  assign ge  = t >= {1'b0, mc};
  assign d   = t[XLEN-1:0] - mc;

  assign last = cnt == CW'(XLEN - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q  <= '0;
      neg   <= 1'b0;
      neg_r <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      mc    <= '0;
      cnt   <= '0;
    end else if (start) begin
      op_q  <= op;
      neg   <= sa ^ sb;
      neg_r <= sa;
      hi    <= '0;
      lo    <= is_mul(op) ? mb : ma;
      mc    <= is_mul(op) ? ma : mb;
      cnt   <= '0;
    end else if (state == S_MUL) begin
      hi  <= sum[XLEN:1];
      lo  <= {sum[0], lo[XLEN-1:1]};
      cnt <= cnt + 1'b1;
    end else if (state == S_DIV) begin
      hi  <= ge ? d : t[XLEN-1:0];
      lo  <= {lo[XLEN-2:0], ge};
      cnt <= cnt + 1'b1;
    end
  end

  assign pf = neg ? -{hi, lo} : {hi, lo};
  assign qf = neg ? -lo : lo;
  assign rf = neg_r ? -hi : hi;

  always_comb begin
    res = '0;
    unique case (op_q)
      OP_MUL:                        res = pf[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  res = pf[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               res = qf;
      OP_REM, OP_REMU:               res = rf;
      default:                       res = '0;
    endcase
  end
endmodule

// File: rtl/alu_iter.sv
// Multi-cycle ALU: single-cycle simple ops, iterative RV32M/RV64M mul/div.
// in_valid/in_ready accept op,r1,r2; out_valid/out_ready return result,overflow.
module alu_iter
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] r1,
  input  logic [XLEN-1:0] r2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            overflow
);
  localparam int SW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state;
  state_t          state_n;
  state_t          disp;
  logic            accept;
  logic            start;
  logic            last;
  logic            mul_op;
  logic            div_op;
  logic            fast;
  logic [XLEN-1:0] md_res;
  logic [XLEN-1:0] simple_res;
  logic            simple_ovf;
  logic [XLEN-1:0] fast_res;
  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] diff;
  logic [SW-1:0]   sh;
  logic            add_ovf;
  logic            sub_ovf;

  assign in_ready  = (state == S_IDLE) | ((state == S_DONE) & out_ready);
  assign accept    = in_valid & in_ready & ~flush;
  assign out_valid = state == S_DONE;

  assign mul_op = is_mul(op);
  assign div_op = is_div(op);
  // divide by zero and signed MIN/-1 resolve without iterating
  assign fast = div_op & ((r2 == '0) |
                (((op == OP_DIV) | (op == OP_REM)) & (r1 == MIN) & (r2 == '1)));
  assign start = accept & (mul_op | (div_op & ~fast));

  assign fast_res = (r2 == '0)
                  ? (((op == OP_DIV) | (op == OP_DIVU)) ? '1 : r1)
                  : ((op == OP_DIV) ? MIN : '0);

  assign sum  = r1 + r2;
  assign diff = r1 - r2;
  assign sh   = r2[SW-1:0];
  assign add_ovf = (r1[XLEN-1] == r2[XLEN-1]) & (sum[XLEN-1] != r1[XLEN-1]);
  assign sub_ovf = (r1[XLEN-1] != r2[XLEN-1]) & (diff[XLEN-1] != r1[XLEN-1]);

  always_comb begin
    simple_res = '0;
    simple_ovf = 1'b0;
    unique case (op)
      OP_ADD:  begin simple_res = sum;  simple_ovf = add_ovf; end
      OP_SUB:  begin simple_res = diff; simple_ovf = sub_ovf; end
      OP_NOT:  simple_res = ~r1;
      OP_AND:  simple_res = r1 & r2;
      OP_OR:   simple_res = r1 | r2;
      OP_XOR:  simple_res = r1 ^ r2;
      OP_SLT:  begin
        simple_res = {{(XLEN-1){1'b0}}, $signed(r1) < $signed(r2)};
        simple_ovf = sub_ovf;
      end
      OP_SLTU: simple_res = {{(XLEN-1){1'b0}}, r1 < r2};
      OP_SLL:  simple_res = r1 << sh;
      OP_SRL:  simple_res = r1 >> sh;
      OP_SRA:  simple_res = $signed(r1) >>> sh;
      OP_EQ:   simple_res = {{(XLEN-1){1'b0}}, r1 == r2};
      default: simple_res = '0;
    endcase
  end

  always_comb begin
    disp = S_DONE;
    unique case (1'b1)
      mul_op:          disp = S_MUL;
      div_op && !fast: disp = S_DIV;
      default:         disp = S_DONE;
    endcase
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE, S_DONE: begin
        if ((state == S_DONE) && out_ready) state_n = S_IDLE;
        if (accept) state_n = disp;
      end
      S_MUL, S_DIV: if (last) state_n = S_FIX;
      S_FIX:        state_n = S_DONE;
      default:      state_n = S_IDLE;
    endcase
    if (flush) state_n = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result   <= '0;
      overflow <= 1'b0;
    end else if (accept && !start) begin
      result   <= div_op ? fast_res : simple_res;
      overflow <= div_op ? 1'b0 : simple_ovf;
    end else if ((state == S_FIX) && !flush) begin
      result   <= md_res;
      overflow <= 1'b0;
    end
  end

  alu_muldiv_iter #(.XLEN(XLEN)) u_md (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (r1),
    .b     (r2),
    .state (state),
    .last  (last),
    .res   (md_res)
  );
endmodule

// File: doc/alu_iter.md
# alu_iter

Parametrised multi-cycle successor to the single-cycle integer ALU in the NPC execute stage. It keeps the twelve existing ALU operations and their encodings, and adds RV32M/RV64M multiply, divide and remainder. Operations are accepted through a valid/ready handshake and results are returned through a second one. Simple operations complete in one cycle; multiply and divide are iterative, which lets the block stall the execute stage without a combinational long path.

## Interface
- `XLEN`, 32: operand/result width (32 or 64).
- `clk` input 1: clock.
- `rst` input 1: synchronous, active-high reset.
- `flush` input 1: abandon in-flight op (pipeline redirect).
- `in_valid` input 1: operation offered.
- `in_ready` output 1: block can accept.
- `op` input 5: operation code.
- `r1`, `r2` input XLEN: operands.
- `out_valid` output 1: result held.
- `out_ready` input 1: consumer takes result.
- `result` output XLEN: result.
- `overflow` output 1: signed overflow, valid for ADD, SUB and SLT; 0 for all other ops.

## Operation
- Op codes 0x00–0x0B are identical to the existing ALU: ADD, SUB, NOT(r1), AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA, EQ.
  - SLT, SLTU and EQ return 1 or 0.
  - Shift amount is `r2[$clog2(XLEN)-1:0]`.
- Multiply and divide ops:
  - 0x0C MUL: low XLEN bits of the product.
  - 0x0D MULH: high XLEN bits, signed×signed.
  - 0x0E MULHSU: high XLEN bits, signed×unsigned.
  - 0x0F MULHU: high XLEN bits, unsigned×unsigned.
  - 0x10 DIV, 0x11 DIVU, 0x12 REM, 0x13 REMU.
- Undefined codes 0x14–0x1F: result 0, overflow 0, one-cycle latency.
- States:
  - IDLE: accepts ops.
  - MUL: XLEN shift-add iterations on operand magnitudes.
  - DIV: XLEN restoring iterations on magnitudes.
  - FIX: sign correction of quotient, remainder or product.
  - DONE: result held.
- Transitions:
  - IDLE → DONE (simple op or division fast path), MUL or DIV.
  - MUL → FIX after XLEN iterations; DIV → FIX after XLEN iterations.
  - FIX → DONE.
  - DONE → IDLE on `out_ready` with no new accept.
  - DONE → next state on `out_ready` together with an accept.
- Division fast paths, one cycle, go directly to DONE:
  - Divide by zero: quotient all ones, remainder = r1.
  - Signed MIN / −1: quotient = MIN, remainder = 0.
- Remainder sign follows the dividend; quotient sign is the XOR of the operand signs. Arithmetic is modulo 2^XLEN.
- Handshake:
  - `in_ready = (state==IDLE) | (state==DONE & out_ready)`.
  - Operands and op are captured on accept; later changes on `r1`, `r2` and `op` have no effect.
  - `result` and `overflow` are stable while `out_valid & !out_ready`.
- `flush` or `rst`: state → IDLE and `out_valid` → 0 at the next edge. `flush` has priority over a simultaneous accept, and the offered op is dropped.
- Reset values: `out_valid` 0, `result` 0, `overflow` 0, `in_ready` 1 (the state is IDLE).

## Timing
- Accept edge = E0.
- Simple ops and division fast paths: `out_valid` high after E1.
- MUL*: `out_valid` high after E(XLEN+2), i.e. 34 cycles for XLEN=32.
- DIV/REM: `out_valid` high after E(XLEN+2).
- Back-to-back simple ops with `out_ready` held high: one result per cycle.
- Flush during MUL or DIV: nothing is emitted for that op; `in_ready` is high the cycle after the flush.

## Structure
- Shared package `alu_pkg`:
  - op code localparams (0x00–0x13);
  - state enum;
  - `XLEN_DEFAULT`.
- Sub-module `alu_muldiv_iter`:
  - owns the MUL, DIV and FIX iteration datapath and the iteration counter (`$clog2(XLEN)+1` bits);
  - start/done interface to the top-level FSM.
- The top level holds the combinational simple-op datapath, the FSM and the output registers.

## Test plan
- ADD 0x7FFFFFFF + 1 → result 0x80000000, overflow 1, `out_valid` one cycle after accept. SLT −1 < 1 → 1, overflow 0.
- MULH 0xFFFFFFFF × 0xFFFFFFFF → 0; MULHU on the same operands → 0xFFFFFFFE. `out_valid` exactly 34 cycles after accept.
- DIV −7 / 2 → −3; REM −7 / 2 → −1. DIV by 0 → 0xFFFFFFFF; REMU 5 / 0 → 5. DIV 0x80000000 / −1 → 0x80000000; the last two cases take one cycle.
- Backpressure: `out_ready` held low for 5 cycles after a DIV completes → `result` stable and `in_ready` low throughout. Release `out_ready` with a new ADD offered in the same cycle → ADD accepted and its result valid next cycle.
- Flush at iteration 10 of a MUL → no output for the MUL. A subsequent XOR 0xF0 ^ 0xFF → 0x0F.
- Reset mid-DIV (`rst` high for 1 cycle) → `out_valid` 0 and `in_ready` 1 the next cycle. Repeat the directed cases with XLEN=64.
